// File: rtl/fetch_mem_arbiter_pkg.sv
// Shared types and parameter defaults for the fetch/mem bus arbiter.
package fetch_mem_arbiter_pkg;

   localparam int unsigned DEF_DATA_WIDTH  = 32;
   localparam int unsigned DEF_ADDR_WIDTH  = 32;
   localparam int unsigned DEF_BURST_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RSP
   } arb_state_t;

   typedef enum logic {
      FETCH = 1'b0,
      MEM   = 1'b1
   } req_id_t;

endpackage

// File: rtl/fetch_mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the one
// that was not granted last wins.
module rr_pick2
   import fetch_mem_arbiter_pkg::*;
(
   input  logic    fetch_valid,
   input  logic    mem_valid,
   input  req_id_t last_grant,
   output req_id_t grant,
   output logic    any
);

   // Winner selection
   always_comb begin
      any   = fetch_valid | mem_valid;
      grant = FETCH;
      if (fetch_valid && mem_valid)
         grant = (last_grant == FETCH) ? MEM : FETCH;
      else if (mem_valid)
         grant = MEM;
   end

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Arbitrates fetch and mem requesters onto one downstream bus; one
// transaction (command + all response beats) in flight at a time.
module fetch_mem_arbiter
   import fetch_mem_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned BURST_WIDTH = DEF_BURST_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fetch_req_valid,
   output logic                   fetch_req_ready,
   input  logic [ADDR_WIDTH-1:0]  fetch_req_addr,
   input  logic                   fetch_req_write,
   input  logic [BURST_WIDTH-1:0] fetch_req_burst,
   input  logic [DATA_WIDTH-1:0]  fetch_req_wdata,
   output logic                   fetch_rsp_valid,
   output logic [DATA_WIDTH-1:0]  fetch_rsp_data,
   input  logic                   mem_req_valid,
   output logic                   mem_req_ready,
   input  logic [ADDR_WIDTH-1:0]  mem_req_addr,
   input  logic                   mem_req_write,
   input  logic [BURST_WIDTH-1:0] mem_req_burst,
   input  logic [DATA_WIDTH-1:0]  mem_req_wdata,
   output logic                   mem_rsp_valid,
   output logic [DATA_WIDTH-1:0]  mem_rsp_data,
   output logic                   bus_valid,
   input  logic                   bus_ready,
   output logic [ADDR_WIDTH-1:0]  bus_addr,
   output logic                   bus_write,
   output logic [BURST_WIDTH-1:0] bus_burst,
   output logic [DATA_WIDTH-1:0]  bus_wdata,
   input  logic                   bus_rsp_valid,
   input  logic [DATA_WIDTH-1:0]  bus_rsp_data,
   output logic                   err
);

   // One extra bit so an all-ones burst (2^BURST_WIDTH beats) fits.
   localparam logic [BURST_WIDTH:0] CNT_ONE = (BURST_WIDTH+1)'(1);

   arb_state_t             state, state_nxt;
   req_id_t                grant, last_grant, pick_id;
   logic                   pick_any;
   logic [BURST_WIDTH:0]   beat_cnt;
   logic [ADDR_WIDTH-1:0]  cap_addr;
   logic                   cap_write;
   logic [BURST_WIDTH-1:0] cap_burst;
   logic [DATA_WIDTH-1:0]  cap_wdata;
   logic                   bus_accept, last_beat, stray_rsp;

   rr_pick2 u_pick (
      .fetch_valid (fetch_req_valid),
      .mem_valid   (mem_req_valid),
      .last_grant  (last_grant),
      .grant       (pick_id),
      .any         (pick_any)
   );

   assign bus_accept = (state == ISSUE) && bus_ready;
   assign last_beat  = (state == WAIT_RSP) && bus_rsp_valid && (beat_cnt == CNT_ONE);
   assign stray_rsp  = bus_rsp_valid && (state != WAIT_RSP);

   // Next-state and all outputs
   always_comb begin
      state_nxt       = state;
      bus_valid       = 1'b0;
      bus_addr        = '0;
      bus_write       = 1'b0;
      bus_burst       = '0;
      bus_wdata       = '0;
      fetch_req_ready = 1'b0;
      mem_req_ready   = 1'b0;
      fetch_rsp_valid = 1'b0;
      fetch_rsp_data  = '0;
      mem_rsp_valid   = 1'b0;
      mem_rsp_data    = '0;
      case (state)
         IDLE: begin
            if (pick_any)
               state_nxt = ISSUE;
         end
         ISSUE: begin
            bus_valid = 1'b1;
            bus_addr  = cap_addr;
            bus_write = cap_write;
            bus_burst = cap_write ? '0 : cap_burst;
            bus_wdata = cap_wdata;
            if (grant == FETCH)
               fetch_req_ready = bus_ready;
            else
               mem_req_ready = bus_ready;
            if (bus_ready)
               state_nxt = WAIT_RSP;
         end
         WAIT_RSP: begin
            if (bus_rsp_valid) begin
               if (grant == FETCH) begin
                  fetch_rsp_valid = 1'b1;
                  fetch_rsp_data  = bus_rsp_data;
               end else begin
                  mem_rsp_valid = 1'b1;
                  mem_rsp_data  = bus_rsp_data;
               end
            end
            if (last_beat)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Command capture, beat counting and grant history
   always_ff @(posedge clk) begin
      if (rst) begin
         grant      <= FETCH;
         last_grant <= MEM;
         beat_cnt   <= '0;
         cap_addr   <= '0;
         cap_write  <= 1'b0;
         cap_burst  <= '0;
         cap_wdata  <= '0;
      end else begin
         if (state == IDLE && pick_any) begin
            grant <= pick_id;
            if (pick_id == FETCH) begin
               cap_addr  <= fetch_req_addr;
               cap_write <= fetch_req_write;
               cap_burst <= fetch_req_burst;
               cap_wdata <= fetch_req_wdata;
            end else begin
               cap_addr  <= mem_req_addr;
               cap_write <= mem_req_write;
               cap_burst <= mem_req_burst;
               cap_wdata <= mem_req_wdata;
            end
         end
         if (bus_accept)
            beat_cnt <= cap_write ? CNT_ONE : ({1'b0, cap_burst} + CNT_ONE);
         else if (state == WAIT_RSP && bus_rsp_valid)
            beat_cnt <= beat_cnt - CNT_ONE;
         if (last_beat)
            last_grant <= grant;
      end
   end

   // Sticky flag for response beats arriving with no transaction waiting
   always_ff @(posedge clk) begin
      if (rst)
         err <= 1'b0;
      else if (stray_rsp)
         err <= 1'b1;
   end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter: transaction table plus hand-written
// sequences for stray responses and reset mid-transaction.
module tb_fetch_mem_arbiter;
   import fetch_mem_arbiter_pkg::*;

   logic        clk;
   logic        rst;
   logic        fetch_req_valid, fetch_req_ready, fetch_req_write;
   logic [31:0] fetch_req_addr, fetch_req_wdata;
   logic [3:0]  fetch_req_burst;
   logic        fetch_rsp_valid;
   logic [31:0] fetch_rsp_data;
   logic        mem_req_valid, mem_req_ready, mem_req_write;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_burst;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        bus_valid, bus_ready, bus_write;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_burst;
   logic        bus_rsp_valid;
   logic [31:0] bus_rsp_data;
   logic        err;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   fetch_mem_arbiter #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .BURST_WIDTH (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_req_valid (fetch_req_valid),
      .fetch_req_ready (fetch_req_ready),
      .fetch_req_addr  (fetch_req_addr),
      .fetch_req_write (fetch_req_write),
      .fetch_req_burst (fetch_req_burst),
      .fetch_req_wdata (fetch_req_wdata),
      .fetch_rsp_valid (fetch_rsp_valid),
      .fetch_rsp_data  (fetch_rsp_data),
      .mem_req_valid   (mem_req_valid),
      .mem_req_ready   (mem_req_ready),
      .mem_req_addr    (mem_req_addr),
      .mem_req_write   (mem_req_write),
      .mem_req_burst   (mem_req_burst),
      .mem_req_wdata   (mem_req_wdata),
      .mem_rsp_valid   (mem_rsp_valid),
      .mem_rsp_data    (mem_rsp_data),
      .bus_valid       (bus_valid),
      .bus_ready       (bus_ready),
      .bus_addr        (bus_addr),
      .bus_write       (bus_write),
      .bus_burst       (bus_burst),
      .bus_wdata       (bus_wdata),
      .bus_rsp_valid   (bus_rsp_valid),
      .bus_rsp_data    (bus_rsp_data),
      .err             (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_idle(input string tag);
      chk({tag, "_bus_valid"}, bus_valid, 0);
      chk({tag, "_bus_fields"}, {bus_addr, bus_wdata}, 0);
      chk({tag, "_bus_wb"}, {bus_write, bus_burst}, 0);
      chk({tag, "_req_ready"}, {fetch_req_ready, mem_req_ready}, 0);
      chk({tag, "_rsp_valid"}, {fetch_rsp_valid, mem_rsp_valid}, 0);
      chk({tag, "_rsp_data"}, {fetch_rsp_data, mem_rsp_data}, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   // Serves one transaction for requester id starting from IDLE: checks
   // one-cycle issue latency, stall stability, handshake, and beat routing.
   task automatic serve(input req_id_t id, input logic [31:0] addr, input logic wr,
                        input logic [3:0] burst, input logic [31:0] wdata,
                        input int unsigned stall, input logic [31:0] base);
      int unsigned waited;
      int unsigned beats;
      logic [3:0]  exp_burst;
      waited    = 0;
      beats     = wr ? 1 : int'(burst) + 1;
      exp_burst = wr ? 4'd0 : burst;
      @(negedge clk);
      while (!bus_valid && waited < 20) begin
         tick();
         @(negedge clk);
         waited++;
      end
      chk("issue_latency", waited, 1);
      chk("bus_addr", bus_addr, addr);
      chk("bus_write", bus_write, wr);
      chk("bus_burst", bus_burst, exp_burst);
      chk("bus_wdata", bus_wdata, wdata);
      for (int s = 0; s < int'(stall); s++) begin
         chk("stall_ready", {fetch_req_ready, mem_req_ready}, 0);
         tick();
         @(negedge clk);
         chk("stall_valid", bus_valid, 1);
         chk("stall_addr", bus_addr, addr);
         chk("stall_burst", bus_burst, exp_burst);
      end
      bus_ready = 1'b1;
      #1;
      chk("ready_fetch", fetch_req_ready, id == FETCH);
      chk("ready_mem", mem_req_ready, id == MEM);
      tick();
      bus_ready = 1'b0;
      if (id == FETCH) fetch_req_valid = 1'b0;
      else             mem_req_valid   = 1'b0;
      @(negedge clk);
      chk("accepted_bus_valid", bus_valid, 0);
      for (int b = 0; b < int'(beats); b++) begin
         bus_rsp_valid = 1'b1;
         bus_rsp_data  = base + 32'(b);
         #1;
         if (id == FETCH) begin
            chk("beat_fetch_valid", fetch_rsp_valid, 1);
            chk("beat_fetch_data", fetch_rsp_data, base + 32'(b));
            chk("beat_mem_quiet", {mem_rsp_valid, mem_rsp_data}, 0);
         end else begin
            chk("beat_mem_valid", mem_rsp_valid, 1);
            chk("beat_mem_data", mem_rsp_data, base + 32'(b));
            chk("beat_fetch_quiet", {fetch_rsp_valid, fetch_rsp_data}, 0);
         end
         tick();
      end
      bus_rsp_valid = 1'b0;
      bus_rsp_data  = '0;
   endtask

   typedef struct {
      logic        fv;
      logic [31:0] fa;
      logic        fw;
      logic [3:0]  fb;
      logic [31:0] fd;
      logic        mv;
      logic [31:0] ma;
      logic        mw;
      logic [3:0]  mb;
      logic [31:0] md;
      req_id_t     first;
      int unsigned stall;
      logic [31:0] base;
   } vec_t;

   vec_t vecs[6];

   initial begin
      req_id_t id;

      // fv fa      fw fb    fd            mv ma        mw mb    md             first stall base
      vecs[0] = '{1, 32'h100, 0, 4'h0, 32'h0,        1, 32'h200, 0, 4'h0, 32'h0,        FETCH, 0, 32'h1000};
      vecs[1] = '{1, 32'h300, 0, 4'h3, 32'h0,        0, 32'h0,   0, 4'h0, 32'h0,        FETCH, 2, 32'hA};
      vecs[2] = '{1, 32'h700, 0, 4'h1, 32'h0,        1, 32'h800, 0, 4'h0, 32'h0,        MEM,   1, 32'h20};
      vecs[3] = '{0, 32'h0,   0, 4'h0, 32'h0,        1, 32'h40,  1, 4'h7, 32'hDEADBEEF, MEM,   0, 32'h600D};
      vecs[4] = '{1, 32'h400, 0, 4'hF, 32'h0,        1, 32'h500, 1, 4'h2, 32'h12345678, FETCH, 0, 32'h100};
      vecs[5] = '{1, 32'h380, 1, 4'h5, 32'hCAFE0001, 0, 32'h0,   0, 4'h0, 32'h0,        FETCH, 0, 32'h33};

      rst = 1'b1;
      fetch_req_valid = 0; fetch_req_addr = '0; fetch_req_write = 0; fetch_req_burst = '0; fetch_req_wdata = '0;
      mem_req_valid = 0;   mem_req_addr = '0;   mem_req_write = 0;   mem_req_burst = '0;   mem_req_wdata = '0;
      bus_ready = 0; bus_rsp_valid = 0; bus_rsp_data = '0;
      tick();
      tick();
      chk_all_idle("reset");
      rst = 1'b0;

      // Transaction table; tie order follows the round-robin history by hand
      for (int v = 0; v < 6; v++) begin
         fetch_req_valid = vecs[v].fv; fetch_req_addr = vecs[v].fa; fetch_req_write = vecs[v].fw;
         fetch_req_burst = vecs[v].fb; fetch_req_wdata = vecs[v].fd;
         mem_req_valid = vecs[v].mv;   mem_req_addr = vecs[v].ma;   mem_req_write = vecs[v].mw;
         mem_req_burst = vecs[v].mb;   mem_req_wdata = vecs[v].md;
         for (int k = 0; k < 2; k++) begin
            id = (k == 0) ? vecs[v].first : ((vecs[v].first == FETCH) ? MEM : FETCH);
            if (id == FETCH && vecs[v].fv)
               serve(FETCH, vecs[v].fa, vecs[v].fw, vecs[v].fb, vecs[v].fd,
                     (k == 0) ? vecs[v].stall : 0, vecs[v].base + 32'(k * 32'h100));
            else if (id == MEM && vecs[v].mv)
               serve(MEM, vecs[v].ma, vecs[v].mw, vecs[v].mb, vecs[v].md,
                     (k == 0) ? vecs[v].stall : 0, vecs[v].base + 32'(k * 32'h100));
         end
      end
      chk("err_after_table", err, 0);

      // Stray response beat while IDLE: dropped, err becomes sticky
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = 32'h55;
      #1;
      chk("stray_rsp_valid", {fetch_rsp_valid, mem_rsp_valid}, 0);
      chk("stray_rsp_data", {fetch_rsp_data, mem_rsp_data}, 0);
      tick();
      bus_rsp_valid = 1'b0;
      bus_rsp_data  = '0;
      @(negedge clk);
      chk("err_set", err, 1);
      tick();
      tick();
      tick();
      @(negedge clk);
      chk("err_sticky", err, 1);

      // Reset after one of four beats; last grant was fetch before this
      fetch_req_valid = 1'b1; fetch_req_addr = 32'h900; fetch_req_write = 0; fetch_req_burst = 4'h3;
      tick();
      @(negedge clk);
      chk("abort_issue", bus_valid, 1);
      bus_ready = 1'b1;
      tick();
      bus_ready = 1'b0;
      fetch_req_valid = 1'b0;
      bus_rsp_valid = 1'b1;
      bus_rsp_data  = 32'h77;
      #1;
      chk("abort_beat1", fetch_rsp_valid, 1);
      tick();
      bus_rsp_valid = 1'b0;
      bus_rsp_data  = '0;
      rst = 1'b1;
      tick();
      chk_all_idle("midrst");
      rst = 1'b0;

      // After reset fetch is favoured again on a tie
      fetch_req_valid = 1; fetch_req_addr = 32'hA00; fetch_req_write = 0; fetch_req_burst = 4'h0; fetch_req_wdata = '0;
      mem_req_valid = 1;   mem_req_addr = 32'hB00;   mem_req_write = 0;   mem_req_burst = 4'h0;   mem_req_wdata = '0;
      serve(FETCH, 32'hA00, 0, 4'h0, 32'h0, 0, 32'h5A);
      serve(MEM, 32'hB00, 0, 4'h0, 32'h0, 0, 32'hA5);
      @(negedge clk);
      chk("final_err", err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_mem_arbiter.md
FETCH_MEM_ARBITER -- requirements
Module: fetch_mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data width of all data ports.
REQ-002 Parameter ADDR_WIDTH, default 32, address width of all address ports.
REQ-003 Parameter BURST_WIDTH, default 4, width of the burst field; value = beats-1.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 {fetch,mem}_req_valid  in  1  request present; held stable until accepted.
REQ-007 {fetch,mem}_req_ready  out  1  request accepted this cycle.
REQ-008 {fetch,mem}_req_addr  in  ADDR_WIDTH  start address.
REQ-009 {fetch,mem}_req_write  in  1  1=write (single beat), 0=read.
REQ-010 {fetch,mem}_req_burst  in  BURST_WIDTH  read beats-1; ignored for writes.
REQ-011 {fetch,mem}_req_wdata  in  DATA_WIDTH  write data.
REQ-012 {fetch,mem}_rsp_valid  out  1  response beat (read data or write ack) for that requester.
REQ-013 {fetch,mem}_rsp_data  out  DATA_WIDTH  response data; 0 when rsp_valid=0.
REQ-014 bus_valid / bus_ready  out / in  1  downstream command handshake.
REQ-015 bus_addr, bus_write, bus_burst, bus_wdata  out  per REQ-008..011  granted command.
REQ-016 bus_rsp_valid / bus_rsp_data  in  1 / DATA_WIDTH  downstream response beat.
REQ-017 err  out  1  sticky protocol-error flag.

Function
REQ-018 States IDLE, ISSUE, WAIT_RSP; exactly one active.
REQ-019 IDLE: if any req_valid, register the winner (REQ-020), capture its addr/write/burst/wdata, enter ISSUE next cycle; else stay.
REQ-020 Arbitration round-robin: single requester wins; both valid -> the one not in last_grant wins; last_grant updated only on transaction completion.
REQ-021 ISSUE: bus_valid=1 with captured fields; granted req_ready = bus_ready, other req_ready=0; on bus_valid&bus_ready enter WAIT_RSP.
REQ-022 Beat counter loaded on bus accept: burst+1 for reads, 1 for writes; bus_burst driven 0 for writes.
REQ-023 WAIT_RSP: each bus_rsp_valid forwards data to granted rsp_valid/rsp_data same cycle (combinational), counter decrements; on last beat update last_grant and return to IDLE.
REQ-024 Latency: request valid in IDLE at cycle N -> bus_valid at N+1; minimum inter-transaction gap of one IDLE cycle after last response beat.
REQ-025 Non-granted requester: req_ready=0, rsp_valid=0 at all times.
REQ-026 bus_rsp_valid in IDLE or ISSUE is ignored (not forwarded) and sets err; err stays 1 until reset.
REQ-027 req_valid deasserted by granted requester after capture has no effect; captured command completes.
REQ-028 Max burst (all ones) counts 2^BURST_WIDTH beats without counter overflow.

Reset
REQ-029 rst at clock edge: state=IDLE, counter=0, last_grant=mem (fetch favoured first), err=0, captured fields=0.
REQ-030 Outputs during/after reset: all valid/ready=0, bus_* data fields=0, rsp_data=0.
REQ-031 Reset mid-ISSUE or mid-WAIT_RSP aborts the transaction; downstream slave is reset with the same rst.

Structure
REQ-032 Shared package fetch_mem_arbiter_pkg holds the state enum, requester-id enum (FETCH, MEM) and parameter defaults.
REQ-033 One sub-module rr_pick2: combinational two-way round-robin picker (valids, last_grant -> grant id, any).

Verification
REQ-034 After reset, both valid, reads burst=0 addr 0x100/0x200 -> fetch served first (bus_addr 0x100), then mem (0x200).
REQ-035 Fetch read burst=3, bus_ready held 0 for 2 cycles -> bus_valid held, fields stable; 4 rsp beats 0xA..0xD appear only on fetch_rsp_data.
REQ-036 Continuous requests from both -> grants alternate fetch, mem, fetch, mem over 4 transactions.
REQ-037 Mem write addr 0x40 wdata 0xDEADBEEF -> bus_write=1, bus_burst=0; one ack beat -> mem_rsp_valid=1 once, return to IDLE.
REQ-038 bus_rsp_valid pulse while IDLE -> no rsp_valid on either port, err=1 until rst.
REQ-039 rst asserted in WAIT_RSP after 1 of 4 beats -> next cycle IDLE, all outputs 0, err=0, fetch favoured.
